// File: rtl/uart_rx_buffered_if.sv
// uart_rx_buffered_if: downstream FIFO read side plus receive status pulses
interface uart_rx_buffered_if #(parameter int NB_DATA = 8);
    logic               rd;
    logic [NB_DATA-1:0] data_rx;
    logic               empty_rx;
    logic               full_rx;
    logic               overrun;
    logic               frame_err;
    modport master(output rd, input data_rx, empty_rx, full_rx, overrun, frame_err);
    modport slave(input rd, output data_rx, empty_rx, full_rx, overrun, frame_err);
endinterface

// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: 16x oversampled 8N1 receiver feeding a show-ahead FIFO
module uart_rx_buffered #(
    parameter int NB_DATA = 8,
    parameter int SB_TICK = 16,
    parameter int FIFO_AW = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_tick,
    input  logic                  rx,
    uart_rx_buffered_if.slave     bus
);
    localparam int SW    = $clog2(SB_TICK > 16 ? SB_TICK : 16);
    localparam int NW    = $clog2(NB_DATA);
    localparam int DEPTH = 2 ** FIFO_AW;

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        START = 4'b0010,
        DATA  = 4'b0100,
        STOP  = 4'b1000
    } state_t;

    state_t             r_state;
    logic [SW-1:0]      r_s;
    logic [NW-1:0]      r_n;
    logic [NB_DATA-1:0] r_shift;
    logic [1:0]         r_sync;
    logic               r_frame_err;
    logic               r_overrun;
    logic [FIFO_AW:0]   r_wr_ptr;
    logic [FIFO_AW:0]   r_rd_ptr;
    logic [NB_DATA-1:0] r_mem [DEPTH];

    logic w_rx_s;
    logic w_push;
    logic w_empty;
    logic w_full;
    logic w_rd;
    logic w_write;

    assign w_rx_s  = r_sync[1];
    assign w_push  = (r_state == STOP) && s_tick && (r_s == SW'(SB_TICK - 1)) && w_rx_s;
    assign w_empty = r_wr_ptr == r_rd_ptr;
    assign w_full  = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                     (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
    assign w_rd    = bus.rd && !w_empty;
    // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign w_write = w_push && (!w_full || w_rd);

    assign bus.data_rx   = r_mem[r_rd_ptr[FIFO_AW-1:0]];
    assign bus.empty_rx  = w_empty;
    assign bus.full_rx   = w_full;
    assign bus.overrun   = r_overrun;
    assign bus.frame_err = r_frame_err;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_s         <= '0;
            r_n         <= '0;
            r_shift     <= '0;
            r_sync      <= 2'b11;
            r_frame_err <= 1'b0;
        end else begin
            r_sync      <= {r_sync[0], rx};
            r_frame_err <= 1'b0;
            case (r_state)
                IDLE: if (!w_rx_s) begin
                    r_state <= START;
                    r_s     <= '0;
                end
                START: if (s_tick) begin
                    if (r_s == SW'(7)) begin
                        r_state <= w_rx_s ? IDLE : DATA;
                        r_s     <= '0;
                        r_n     <= '0;
                    end else r_s <= r_s + 1'b1;
                end
                DATA: if (s_tick) begin
                    if (r_s == SW'(15)) begin
                        r_shift <= {w_rx_s, r_shift[NB_DATA-1:1]};
                        r_s     <= '0;
                        if (r_n == NW'(NB_DATA - 1)) r_state <= STOP;
                        else r_n <= r_n + 1'b1;
                    end else r_s <= r_s + 1'b1;
                end
                STOP: if (s_tick) begin
                    if (r_s == SW'(SB_TICK - 1)) begin
                        r_state     <= IDLE;
                        r_frame_err <= !w_rx_s;
                    end else r_s <= r_s + 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_overrun <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_overrun <= w_push && w_full && !w_rd;
            if (w_write) begin
                r_mem[r_wr_ptr[FIFO_AW-1:0]] <= r_shift;
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end
endmodule

// File: doc/uart_rx_buffered.md
Name: uart_rx_buffered

Overview:
Receive front end of the UART-ALU datapath. It oversamples the serial rx line at 16x baud, deframes 8N1 characters LSB-first and pushes good bytes into a small show-ahead FIFO. The FIFO exposes data_rx/empty_rx/rd to the downstream command interface FSM. That FSM peeks data_rx while empty_rx is low and pops with a one-cycle rd.

Parameters:
NB_DATA, 8, data bits per character and FIFO word width
SB_TICK, 16, s_tick count for one stop bit (16 = 1 stop bit)
FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW (default 4)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (reset==0 resets on the clock edge)
s_tick  input  1  one-cycle strobe at 16x baud from the baud generator
rx  input  1  asynchronous serial line, idle high
rd  input  1  pop request from downstream; honoured only when empty_rx==0
data_rx  output  NB_DATA  head of FIFO (show-ahead), valid while empty_rx==0
empty_rx  output  1  FIFO empty
full_rx  output  1  FIFO full
overrun  output  1  one-cycle pulse: completed byte dropped because FIFO full
frame_err  output  1  one-cycle pulse: stop bit sampled low, byte discarded

Behaviour:
- Reset (reset==0 at clk edge):
  - FSM=IDLE; tick and bit counters 0.
  - Shift register 0; synchroniser flops 1.
  - FIFO pointers 0; memory cleared.
  - Outputs: data_rx=0, empty_rx=1, full_rx=0, overrun=0, frame_err=0.
  - Reset mid-frame discards the partial byte and all FIFO contents.
- rx passes through a 2-flop synchroniser (rx_s). All sampling uses rx_s.
- FSM (one-hot, 4 states). Counter s counts s_tick; n counts bits.
  - IDLE: rx_s==0 -> START, s=0.
  - START: on s_tick, s==7 (mid start bit):
    - rx_s==0 -> DATA, s=0, n=0.
    - rx_s==1 -> glitch, back to IDLE, nothing pushed.
    - Otherwise s++.
  - DATA: on s_tick, s==15 -> shift = {rx_s, shift[NB_DATA-1:1]}, s=0.
    - n==NB_DATA-1 -> STOP, else n++.
    - Otherwise s++.
  - STOP: on s_tick, s==SB_TICK-1 -> IDLE.
    - rx_s==1 -> push shift into FIFO.
    - rx_s==0 -> frame_err=1 for exactly that cycle, no push.
  - No s_tick -> counters and state hold.
- FIFO, show-ahead:
  - data_rx = mem[rd_ptr] combinationally. push writes mem[wr_ptr].
  - Pointers are FIFO_AW+1 bits wide and wrap naturally.
  - empty_rx when pointers are equal. full_rx when the MSBs differ and the rest are equal.
- FIFO boundary rules:
  - rd while empty: ignored, no pointer change.
  - push while full and no rd: byte dropped, overrun=1 for one cycle, contents unchanged.
  - push and rd in the same cycle:
    - When full, both occur; no overrun, full_rx stays 1.
    - When empty, the push occurs, rd is ignored, and empty_rx=0 next cycle.
    - Otherwise both occur; occupancy is unchanged.
- Latency: push occurs at the edge where the STOP sample is taken. empty_rx falls and data_rx is valid in the following cycle.
- rd is a single-cycle pop. Holding rd high pops one entry per cycle.

Test Plan:
1. Hold reset=0 for 2 cycles, then reset=1 -> empty_rx=1, full_rx=0, data_rx=0x00, overrun=0, frame_err=0.
2. s_tick every cycle; send frame 0xFF -> about 160 cycles later empty_rx=0, data_rx=0xFF. Pulse rd for 1 cycle -> empty_rx=1 next cycle.
3. Send 0xFF, 0x05, 0x0A, 0x00 with no rd -> full_rx=1, data_rx=0xFF.
   - Send 0x33 -> overrun pulses once; FIFO unchanged.
   - Pop 4 times -> sequence 0xFF, 0x05, 0x0A, 0x00, then empty_rx=1.
4. Drive rx low for 4 ticks, then high -> no push, FSM returns to IDLE. Next frame 0xA5 -> data_rx=0xA5.
5. Send 0x5A with stop bit driven 0 -> frame_err high for exactly 1 cycle; empty_rx stays 1.
6. FIFO holds 0x11; assert reset=0 during data bit 3 of frame 0x77 -> empty_rx=1, FSM IDLE. Next frame 0x3C -> data_rx=0x3C, single entry.
